// File: rtl/tm_lif_bank.sv
// Time-multiplexed bank of leaky integrate-and-fire neurons. A single shared datapath
// updates one neuron slot per enabled cycle and reports each result one cycle later.
module tm_lif_bank #(
    parameter int  N_NEURONS      = 8,
    parameter int  WIDTH          = 8,
    parameter int  LEAK_SHIFT     = 1,
    parameter int  REFRAC         = 2,
    parameter int  DEFAULT_THRESH = 127,
    parameter int  RESET_MODE     = 0,
    localparam int IDX_W          = $clog2(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [WIDTH-1:0]     current,
    input  logic                 thr_we,
    input  logic [IDX_W-1:0]     thr_addr,
    input  logic [WIDTH-1:0]     thr_data,
    output logic                 spike_valid,
    output logic [IDX_W-1:0]     spike_idx,
    output logic                 spike,
    output logic [WIDTH-1:0]     state_out,
    output logic                 sweep_done,
    output logic [N_NEURONS-1:0] spikes
);
    localparam int RW = (REFRAC < 1) ? 1 : $clog2(REFRAC + 1);
    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(N_NEURONS - 1);

    logic [WIDTH-1:0]     mem    [N_NEURONS];
    logic [WIDTH-1:0]     thr    [N_NEURONS];
    logic [RW-1:0]        refrac [N_NEURONS];
    logic [IDX_W-1:0]     ptr;
    logic [N_NEURONS-1:0] acc;

    logic [WIDTH-1:0]     v;
    logic [WIDTH-1:0]     thr_cur;
    logic [WIDTH:0]       sum_raw;
    logic [WIDTH-1:0]     sum;
    logic [WIDTH-1:0]     mem_next;
    logic                 refractory;
    logic                 fire;
    logic [N_NEURONS-1:0] acc_next;

    // NOTE: every signal below is assigned on every path through the block, so no latch can form.
    always_comb begin
        v          = mem[ptr];
        thr_cur    = thr[ptr];
        refractory = (refrac[ptr] != '0);
        sum_raw    = {1'b0, current} + {1'b0, v >> LEAK_SHIFT};
        sum        = sum_raw[WIDTH] ? '1 : sum_raw[WIDTH-1:0];
        fire       = !refractory && (sum >= thr_cur);
        if (refractory) begin
            mem_next = '0;
        end else if (fire) begin
            mem_next = (RESET_MODE == 1) ? sum - thr_cur : '0;
        end else begin
            mem_next = sum;
        end
        acc_next = acc | ({{(N_NEURONS-1){1'b0}}, fire} << ptr);
    end

    // NOTE: the neuron arrays are plain registers with defined reset contents, so they are cleared here.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                mem[i]    <= '0;
                thr[i]    <= WIDTH'(DEFAULT_THRESH);
                refrac[i] <= '0;
            end
            ptr         <= '0;
            acc         <= '0;
            spike_valid <= 1'b0;
            spike_idx   <= '0;
            spike       <= 1'b0;
            state_out   <= '0;
            sweep_done  <= 1'b0;
            spikes      <= '0;
        end else begin
            spike_valid <= en;
            spike       <= en & fire;
            sweep_done  <= en && (ptr == LAST_SLOT);
            if (en) begin
                mem[ptr] <= mem_next;
                if (refractory) begin
                    refrac[ptr] <= refrac[ptr] - RW'(1);
                end else if (fire) begin
                    refrac[ptr] <= RW'(REFRAC);
                end
                spike_idx <= ptr;
                state_out <= mem_next;
                if (ptr == LAST_SLOT) begin
                    spikes <= acc_next;
                    acc    <= '0;
                end else begin
                    acc <= acc_next;
                end
                ptr <= ptr + IDX_W'(1);
            end
            // Comparison above already read the old threshold for a same-slot write.
            if (thr_we) begin
                thr[thr_addr] <= thr_data;
            end
        end
    end
endmodule

// File: doc/tm_lif_bank.md
Name: tm_lif_bank

Overview:
- Parametrised, time-multiplexed bank of leaky integrate-and-fire neurons sharing one update datapath.
- Round-robin slot pointer updates one neuron per enabled cycle, with:
  - per-neuron programmable thresholds
  - refractory counters
  - selectable post-spike reset mode
- Sits between the stimulus/current source and the spike consumer.
- Emits an indexed spike stream plus a per-sweep spike vector.

Parameters:
- N_NEURONS, 8, neuron count (power of two, ≥2); IDX_W = log2(N_NEURONS)
- WIDTH, 8, membrane/current/threshold width
- LEAK_SHIFT, 1, leak = right shift of membrane by this amount per update (0 ≤ LEAK_SHIFT < WIDTH)
- REFRAC, 2, sweeps a neuron stays refractory after a spike (0 = none)
- DEFAULT_THRESH, 127, threshold loaded into every neuron at reset
- RESET_MODE, 0, post-spike membrane: 0 = clear to 0, 1 = subtract threshold

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  advance/update enable
- current  in  WIDTH  input current for the slot currently addressed
- thr_we  in  1  threshold write strobe
- thr_addr  in  IDX_W  neuron index for threshold write
- thr_data  in  WIDTH  threshold value
- spike_valid  out  1  registered result strobe for one slot update
- spike_idx  out  IDX_W  neuron index of the reported update
- spike  out  1  neuron spike_idx fired on this update
- state_out  out  WIDTH  post-update membrane of neuron spike_idx
- sweep_done  out  1  pulse with the result of slot N_NEURONS-1
- spikes  out  N_NEURONS  spike vector of the last completed sweep

Behaviour:
- Reset (rst=1, overrides en and thr_we):
  - all membranes 0; thresholds DEFAULT_THRESH; refractory counters 0; ptr 0
  - all outputs 0, including spikes and the sweep accumulator
- Update cycle (en=1): p = ptr, v = mem[p].
  - If refrac[p] != 0:
    - refrac[p] decrements; mem[p] stays 0; current ignored; spike 0
  - Else:
    - sum = current + (v >> LEAK_SHIFT), computed in WIDTH+1 bits, saturated to 2^WIDTH-1
    - fire = (sum ≥ thr[p]), unsigned
    - On fire: mem[p] = 0 (mode 0) or sum - thr[p] (mode 1); refrac[p] = REFRAC
    - Otherwise: mem[p] = sum
  - ptr = p+1, wrapping N_NEURONS-1 → 0.
- Latency: exactly 1 cycle.
  - In the cycle after an update, spike_valid=1, spike_idx=p, spike=fire, state_out=new mem[p].
  - On idle cycles: spike_valid=0; spike and sweep_done=0; spike_idx and state_out hold their last value.
- en=0: ptr, memories and refractory counters frozen; no result produced.
- Sweep vector: fire ORs into accumulator bit p.
  - On the update of slot N_NEURONS-1, spikes is loaded with the accumulator including that slot's fire. This happens in the same output cycle as sweep_done=1.
  - The accumulator clears on that update.
- Threshold write:
  - Takes effect from the next cycle; accepted regardless of en.
  - If the write addresses the slot being updated in the same cycle, the compare uses the old threshold.
  - thr_data=0 makes that neuron fire on every non-refractory update.
- Mode 1 with thr=0: residual = sum (no subtraction effect); permitted.
- Reset mid-sweep: partial accumulator discarded; next sweep starts at slot 0.

Test Plan:
- Reset, en=1, current=0 for 16 cycles:
  - no spike; state_out=0 throughout
  - sweep_done on output cycles 8 and 16
  - spikes=0
- Defaults, current=64 constant: neuron 0 membrane per sweep is 64, 96, 112, 120, 124, 126, 127.
  - Spike on sweep 7, then state 0.
  - Sweeps 8–9 refractory (state 0, no spike); sweep 10 state 64.
  - spikes=8'hFF after sweep 7.
- RESET_MODE=1, thr[0]=100, current=60:
  - sweep 1 v=60; sweep 2 sum=90
  - sweep 3 sum=105 → spike, residual state_out=5
- thr_we addr 3 data 10, current=10:
  - only spike_idx=3 fires in sweep 1; spikes=8'h08
  - thr[2]=255, current=200: sweep 2 sum 300 saturates to 255 → spike
- Drop en for 4 cycles after slot 4 result:
  - no spike_valid during gap; next result spike_idx=5
  - membranes unchanged
- Assert rst mid-sweep after thr writes:
  - next cycle all outputs 0, thresholds back to 127
  - first result after release is spike_idx=0
